// File: rtl/hdlc_pkg.sv
// Shared constants for the HDLC receive framer: one-hot detector indices,
// detector reset vector and the frame FSM state encoding.
package hdlc_pkg;

  localparam int S0   = 0;
  localparam int S1   = 1;
  localparam int S2   = 2;
  localparam int S3   = 3;
  localparam int S4   = 4;
  localparam int S5   = 5;
  localparam int S6   = 6;
  localparam int ERR  = 7;
  localparam int DISC = 8;
  localparam int FLAG = 9;

  localparam int DET_W = 10;
  localparam logic [DET_W-1:0] DET_RESET = 10'b00_0000_0001;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    OPEN = 2'd1,
    DATA = 2'd2
  } frame_state_e;

endpackage

// File: rtl/hdlc_rx_framer_if.sv
// Octet stream leaving the framer toward the frame buffer.
// Handshake: byte_data/first/last are meaningful while byte_valid=1 and are held
// stable until a cycle with byte_valid=1 and byte_ready=1 transfers the octet.
interface hdlc_rx_framer_if;

  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;
  logic       byte_first;
  logic       byte_last;

  modport master (
    output byte_data,
    output byte_valid,
    output byte_first,
    output byte_last,
    input  byte_ready
  );

  modport slave (
    input  byte_data,
    input  byte_valid,
    input  byte_first,
    input  byte_last,
    output byte_ready
  );

endinterface

// File: rtl/hdlc_stuff_detect.sv
// Combinational next-state and event decode for the one-hot run-of-ones detector.
// The state register itself lives in the framer.
module hdlc_stuff_detect
  import hdlc_pkg::*;
(
  input  logic             din,
  input  logic [DET_W-1:0] state,
  output logic [DET_W-1:0] next_state,
  output logic             stuff,
  output logic             flag,
  output logic             abort
);

  always_comb begin
    next_state = '0;
    // A corrupted (non one-hot) state falls back to S0 rather than locking up.
    if (!$onehot(state)) begin
      next_state = DET_RESET;
    end else if (din) begin
      next_state[S6:S1] = state[S5:S0];
      next_state[S1]    = state[S0] | state[DISC] | state[FLAG];
      next_state[ERR]   = state[S6] | state[ERR];
    end else begin
      next_state[S0]   = (|state[S4:S0]) | state[ERR] | state[DISC] | state[FLAG];
      next_state[DISC] = state[S5];
      next_state[FLAG] = state[S6];
    end
  end

  assign stuff = next_state[DISC];
  assign flag  = next_state[FLAG];
  assign abort = din & state[S6] & $onehot(state);

endmodule

// File: rtl/hdlc_rx_framer.sv
// HDLC receive framer: destuffs the line, strips flags through a 7-bit delay line,
// assembles LSB-first octets and emits them with first/last tags.
module hdlc_rx_framer
  import hdlc_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   bit_valid,
  input  logic                   din,
  hdlc_rx_framer_if.master       byte_if,
  output logic                   frame_abort,
  output logic [CNT_W-1:0]       err_cnt,
  output frame_state_e           o_dbg_fsm,
  output logic [DET_W-1:0]       o_dbg_det
);

  logic [DET_W-1:0] r_det;
  logic [DET_W-1:0] w_det_next;
  logic             w_stuff;
  logic             w_flag;
  logic             w_abort;
  logic             w_data_bit;

  logic [6:0]       r_dl;
  logic [2:0]       r_dl_cnt;
  logic             w_dl_out_vld;
  logic             w_dl_out;

  logic [7:0]       r_asm;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       w_octet;
  logic             w_octet_done;

  logic [7:0]       r_held;
  logic             r_held_vld;
  logic             r_first_pend;

  frame_state_e     r_state;
  frame_state_e     w_state_nxt;

  logic             w_push;
  logic             w_push_last;
  logic             w_ovf;
  logic             w_load_out;
  logic             w_abort_evt;
  logic             w_held_load;
  logic             w_asm_en;

  logic [7:0]       r_out_data;
  logic             r_out_vld;
  logic             r_out_first;
  logic             r_out_last;
  logic             r_abort;
  logic [CNT_W-1:0] r_err_cnt;

  hdlc_stuff_detect u_detect (
    .din        (din),
    .state      (r_det),
    .next_state (w_det_next),
    .stuff      (w_stuff),
    .flag       (w_flag),
    .abort      (w_abort)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_det <= DET_RESET;
    end else if (bit_valid) begin
      r_det <= w_det_next;
    end
  end

  assign w_data_bit = bit_valid & ~w_stuff & ~w_flag & ~w_abort;

  // Valid bits occupy the top r_dl_cnt positions; once full, r_dl[0] is the oldest.
  assign w_dl_out_vld = w_data_bit & (r_dl_cnt == 3'd7);
  assign w_dl_out     = r_dl[0];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_dl     <= '0;
      r_dl_cnt <= '0;
    end else if (bit_valid) begin
      if (w_flag) begin
        r_dl_cnt <= '0;
      end else if (w_data_bit) begin
        r_dl <= {din, r_dl[6:1]};
        if (r_dl_cnt != 3'd7) begin
          r_dl_cnt <= r_dl_cnt + 3'd1;
        end
      end
    end
  end

  assign w_octet      = {w_dl_out, r_asm[7:1]};
  assign w_octet_done = w_dl_out_vld & (r_bit_cnt == 3'd7);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bit_valid) begin
      case (r_state)
        HUNT: if (w_flag) w_state_nxt = OPEN;
        OPEN: begin
          if (w_abort) begin
            w_state_nxt = HUNT;
          end else if (w_dl_out_vld) begin
            w_state_nxt = DATA;
          end
        end
        DATA: begin
          if (w_flag) begin
            w_state_nxt = OPEN;
          end else if (w_abort) begin
            w_state_nxt = HUNT;
          end
        end
        default: w_state_nxt = HUNT;
      endcase
    end
    if (w_ovf) begin
      w_state_nxt = HUNT;
    end
  end

  always_comb begin
    w_push      = 1'b0;
    w_push_last = 1'b0;
    w_abort_evt = 1'b0;
    w_held_load = 1'b0;
    w_asm_en    = 1'b0;
    w_ovf       = 1'b0;
    w_load_out  = 1'b0;
    if (bit_valid) begin
      case (r_state)
        OPEN: w_asm_en = w_dl_out_vld;
        DATA: begin
          if (w_flag) begin
            // A good close needs octet alignment and a completed octet waiting.
            if ((r_bit_cnt == 3'd0) && r_held_vld) begin
              w_push      = 1'b1;
              w_push_last = 1'b1;
            end else begin
              w_abort_evt = 1'b1;
            end
          end else if (w_abort) begin
            w_abort_evt = 1'b1;
          end else begin
            w_asm_en = w_dl_out_vld;
            if (w_octet_done) begin
              w_held_load = 1'b1;
              w_push      = r_held_vld;
            end
          end
        end
        default: ;
      endcase
    end
    w_ovf      = w_push & r_out_vld & ~byte_if.byte_ready;
    w_load_out = w_push & ~w_ovf;
    if (w_ovf) begin
      w_abort_evt = 1'b1;
      w_held_load = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_asm     <= '0;
      r_bit_cnt <= '0;
    end else if (w_abort_evt) begin
      r_asm     <= '0;
      r_bit_cnt <= '0;
    end else if (w_asm_en) begin
      r_asm     <= w_octet;
      r_bit_cnt <= r_bit_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_held     <= '0;
      r_held_vld <= 1'b0;
    end else if (w_abort_evt || w_push_last) begin
      r_held_vld <= 1'b0;
    end else if (w_held_load) begin
      r_held     <= w_octet;
      r_held_vld <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_first_pend <= 1'b0;
    end else if (bit_valid && (r_state == OPEN) && (w_state_nxt == DATA)) begin
      r_first_pend <= 1'b1;
    end else if (w_load_out) begin
      r_first_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_out_data  <= '0;
      r_out_vld   <= 1'b0;
      r_out_first <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_load_out) begin
      r_out_data  <= r_held;
      r_out_vld   <= 1'b1;
      r_out_first <= r_first_pend;
      r_out_last  <= w_push_last;
    end else if (r_out_vld && byte_if.byte_ready) begin
      r_out_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_abort   <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_abort <= w_abort_evt;
      if (w_abort_evt && (r_err_cnt != {CNT_W{1'b1}})) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  assign byte_if.byte_data  = r_out_data;
  assign byte_if.byte_valid = r_out_vld;
  assign byte_if.byte_first = r_out_first;
  assign byte_if.byte_last  = r_out_last;
  assign frame_abort        = r_abort;
  assign err_cnt            = r_err_cnt;
  assign o_dbg_fsm          = r_state;
  assign o_dbg_det          = r_det;

endmodule

// File: tb/tb_hdlc_rx_framer.sv
// Directed bench for hdlc_rx_framer: serial frames in, tagged octets checked
// against hand-computed expectations.
module tb_hdlc_rx_framer;
  import hdlc_pkg::*;

  logic             clk;
  logic             resetn;
  logic             bit_valid;
  logic             din;
  logic             frame_abort;
  logic [7:0]       err_cnt;
  frame_state_e     dbg_fsm;
  logic [DET_W-1:0] dbg_det;

  hdlc_rx_framer_if bif ();

  hdlc_rx_framer #(.CNT_W(8)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .bit_valid   (bit_valid),
    .din         (din),
    .byte_if     (bif.master),
    .frame_abort (frame_abort),
    .err_cnt     (err_cnt),
    .o_dbg_fsm   (dbg_fsm),
    .o_dbg_det   (dbg_det)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int abort_seen = 0;

  // scoreboard entries are {last, first, data}
  logic [9:0] exp_q[$];
  logic [9:0] got_q[$];

  always @(negedge clk) begin
    if (resetn && bif.byte_valid && bif.byte_ready) begin
      got_q.push_back({bif.byte_last, bif.byte_first, bif.byte_data});
    end
    if (resetn && frame_abort) begin
      abort_seen++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      bit_valid = 1'b1;
      din       = v[i];
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits({8'h00, b}, 8);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      bit_valid = 1'b0;
      din       = 1'b0;
    end
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      chk(tag, got_q.pop_front(), exp_q.pop_front());
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    resetn        = 1'b0;
    bit_valid     = 1'b0;
    din           = 1'b0;
    bif.byte_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", bif.byte_valid, 1'b0);
    chk("rst_data",  bif.byte_data, 8'h00);
    chk("rst_first", bif.byte_first, 1'b0);
    chk("rst_last",  bif.byte_last, 1'b0);
    chk("rst_abort", frame_abort, 1'b0);
    chk("rst_err",   err_cnt, 8'd0);
    chk("rst_fsm",   dbg_fsm, HUNT);
    chk("rst_det",   dbg_det, 10'h001);
    resetn = 1'b1;
    idle(2);

    // 1: simple one-octet frame
    send_byte(8'h7E); send_byte(8'hA5); send_byte(8'h7E);
    idle(4);
    exp_q.push_back(10'h3A5);
    check_stream("t1_byte");
    chk("t1_err", err_cnt, 8'd0);
    chk("t1_fsm", dbg_fsm, OPEN);

    // 2: 0xFF with a stuffed zero after five ones
    send_byte(8'h7E); send_bits(16'h01DF, 9); send_byte(8'h7E);
    idle(4);
    exp_q.push_back(10'h3FF);
    check_stream("t2_byte");
    chk("t2_err", err_cnt, 8'd0);
    chk("t2_aborts", abort_seen, 0);

    // 3: seven ones inside a frame
    send_byte(8'h7E); send_byte(8'h12); send_bits(16'h007F, 7);
    idle(4);
    check_stream("t3_none");
    chk("t3_fsm", dbg_fsm, HUNT);
    chk("t3_err", err_cnt, 8'd1);
    chk("t3_aborts", abort_seen, 1);

    // 4: 12 data bits then a flag (not octet aligned)
    send_byte(8'h7E); send_bits(16'h05A3, 12); send_byte(8'h7E);
    idle(4);
    check_stream("t4_none");
    chk("t4_fsm", dbg_fsm, OPEN);
    chk("t4_err", err_cnt, 8'd2);
    chk("t4_aborts", abort_seen, 2);

    // 5: consumer stalled -> overflow on the second push
    bif.byte_ready = 1'b0;
    send_byte(8'h7E); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    send_bits(16'h007E, 7);
    idle(3);
    chk("t5_fsm_hunt", dbg_fsm, HUNT);
    chk("t5_err", err_cnt, 8'd3);
    chk("t5_aborts", abort_seen, 3);
    chk("t5_valid", bif.byte_valid, 1'b1);
    chk("t5_data", bif.byte_data, 8'h01);
    chk("t5_first", bif.byte_first, 1'b1);
    chk("t5_last", bif.byte_last, 1'b0);
    send_bits(16'h0000, 1);
    idle(2);
    chk("t5_fsm_open", dbg_fsm, OPEN);
    bif.byte_ready = 1'b1;
    idle(3);
    exp_q.push_back(10'h101);
    check_stream("t5_drain");

    // 6: idle flags, mid-frame reset, then a clean frame
    send_byte(8'h7E); send_byte(8'h7E); send_byte(8'h7E);
    idle(4);
    check_stream("t6_idle");
    chk("t6_idle_err", err_cnt, 8'd3);
    chk("t6_idle_valid", bif.byte_valid, 1'b0);
    send_byte(8'h7E); send_byte(8'h55); send_bits(16'h0005, 3);
    idle(1);
    chk("t6_fsm_data", dbg_fsm, DATA);
    resetn = 1'b0;
    idle(2);
    chk("t6_rst_valid", bif.byte_valid, 1'b0);
    chk("t6_rst_err", err_cnt, 8'd0);
    chk("t6_rst_abort", frame_abort, 1'b0);
    chk("t6_rst_fsm", dbg_fsm, HUNT);
    chk("t6_rst_det", dbg_det, 10'h001);
    resetn = 1'b1;
    idle(2);
    send_byte(8'h7E); send_byte(8'h55); send_byte(8'h7E);
    idle(4);
    exp_q.push_back(10'h355);
    check_stream("t6_byte");
    chk("t6_err", err_cnt, 8'd0);
    chk("t6_aborts", abort_seen, 3);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
